// File: rtl/esc_pwm_engine_pkg.sv
// Shared definitions for the ESC PWM engine.
// Holds the default timing constants, the scale intermediate widening and
// the sequencer state encoding used by esc_pwm_engine and esc_pwm_channel.
package esc_pwm_engine_pkg;

  localparam int ESC_CLK_FREQ_HZ_DEF  = 38_000_000;
  localparam int MOTOR_RATE_BIT_WIDTH = 8;
  localparam int ESC_FRAME_US         = 2500;
  localparam int ESC_MIN_PULSE_US     = 1000;
  localparam int ESC_MAX_PULSE_US     = 2000;
  localparam int ESC_ARM_FRAMES       = 200;

  // Extra bits on top of RATE_W so rate*(MAX-MIN) cannot overflow (span < 2048).
  localparam int SCALE_EXTRA_W = 11;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_RUN      = 2'd2
  } esc_state_t;

endpackage

// File: rtl/esc_pwm_channel.sv
// One ESC output channel: latches the motor rate at each frame wrap, scales
// it to a pulse width in microseconds clamped to [MIN_PULSE_US, MAX_PULSE_US],
// and compares it against the shared frame counter to form the pulse.
// Ports:
//   sys_clk   clock, all logic on posedge
//   reset     synchronous active-high; forces pwm low
//   load      1-cycle frame wrap; captures rate into the shadow register
//   enable    0 forces pwm low at the next edge (disarmed)
//   use_min   1 selects the minimum pulse instead of the scaled width
//   rate      unsigned motor rate
//   frame_us  current position in the frame, in microseconds
//   pwm       registered ESC pulse
module esc_pwm_channel
  import esc_pwm_engine_pkg::*;
#(
  parameter int RATE_W       = MOTOR_RATE_BIT_WIDTH,
  parameter int MIN_PULSE_US = ESC_MIN_PULSE_US,
  parameter int MAX_PULSE_US = ESC_MAX_PULSE_US,
  parameter int FU_W         = 12
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic              use_min,
  input  logic [RATE_W-1:0] rate,
  input  logic [FU_W-1:0]   frame_us,
  output logic              pwm
);

  localparam int PROD_W = RATE_W + SCALE_EXTRA_W;
  localparam logic [PROD_W-1:0] SPAN = PROD_W'(MAX_PULSE_US - MIN_PULSE_US);

  logic [RATE_W-1:0] rate_p0;
  logic [PROD_W-1:0] scaled_p0;
  logic [FU_W-1:0]   width_p1;
  logic [FU_W-1:0]   eff_width;

  function automatic logic [FU_W-1:0] clamp_width(input logic [PROD_W-1:0] raw);
    if (raw < PROD_W'(MIN_PULSE_US))
      return FU_W'(MIN_PULSE_US);
    else if (raw > PROD_W'(MAX_PULSE_US))
      return FU_W'(MAX_PULSE_US);
    else
      return raw[FU_W-1:0];
  endfunction

  // Stage p0: shadow rate, only updated at the frame wrap so a frame never
  // sees a mid-pulse rate change.
  always_ff @(posedge sys_clk) begin
    if (load)
      rate_p0 <= rate;
  end

  always_comb begin
    scaled_p0 = ((PROD_W'(rate_p0) * SPAN) >> RATE_W) + PROD_W'(MIN_PULSE_US);
  end

  // Stage p1: registered width, settles one cycle after the wrap, long before
  // the counter can reach the falling edge.
  always_ff @(posedge sys_clk) begin
    width_p1 <= clamp_width(scaled_p0);
  end

  assign eff_width = use_min ? FU_W'(MIN_PULSE_US) : width_p1;

  // Output compare stage.
  always_ff @(posedge sys_clk) begin
    if (reset)
      pwm <= 1'b0;
    else
      pwm <= enable && (frame_us < eff_width);
  end

endmodule

// File: rtl/esc_pwm_engine.sv
// Four-channel ESC servo PWM engine with arming sequencer.
// A prescaler derives a 1 us tick from sys_clk, a frame counter spans one PWM
// period, and a sequencer walks DISARMED -> ARMING (minimum pulses for
// ARM_FRAMES frames) -> RUN (live rates). Dropping armed disarms immediately.
// Ports:
//   sys_clk            clock, all logic on posedge
//   reset              synchronous active-high
//   armed              level-sensitive flight enable
//   motor_N_rate       unsigned rate for motor N (1..4)
//   motor_N_pwm        ESC pulse for motor N (1..4)
//   frame_start        1-cycle strobe when the frame counter wraps to 0
//   running            1 while in RUN
module esc_pwm_engine
  import esc_pwm_engine_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = ESC_CLK_FREQ_HZ_DEF,
  parameter int FRAME_US     = ESC_FRAME_US,
  parameter int MIN_PULSE_US = ESC_MIN_PULSE_US,
  parameter int MAX_PULSE_US = ESC_MAX_PULSE_US,
  parameter int ARM_FRAMES   = ESC_ARM_FRAMES,
  parameter int RATE_W       = MOTOR_RATE_BIT_WIDTH
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              armed,
  input  logic [RATE_W-1:0] motor_1_rate,
  input  logic [RATE_W-1:0] motor_2_rate,
  input  logic [RATE_W-1:0] motor_3_rate,
  input  logic [RATE_W-1:0] motor_4_rate,
  output logic              motor_1_pwm,
  output logic              motor_2_pwm,
  output logic              motor_3_pwm,
  output logic              motor_4_pwm,
  output logic              frame_start,
  output logic              running
);

  localparam int DIV  = CLK_FREQ_HZ / 1_000_000;
  localparam int PS_W = $clog2(DIV);
  localparam int FU_W = $clog2(FRAME_US);
  localparam int AC_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

  logic [PS_W-1:0] prescaler;
  logic [FU_W-1:0] frame_us;
  logic [AC_W-1:0] arm_cnt;
  esc_state_t      state;
  logic            us_tick;
  logic            wrap;
  logic            ch_enable;
  logic            ch_use_min;

  logic [RATE_W-1:0] rate_a [4];
  logic [3:0]        pwm_a;

  assign us_tick = (prescaler == PS_W'(DIV - 1));
  assign wrap    = us_tick && (frame_us == FU_W'(FRAME_US - 1));

  // Gating on armed directly lets a disarm cut the lines at the same edge
  // the state falls back to DISARMED.
  assign ch_enable  = armed && (state != ST_DISARMED);
  assign ch_use_min = (state == ST_ARMING);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      prescaler   <= '0;
      frame_us    <= '0;
      arm_cnt     <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
      state       <= ST_DISARMED;
    end else begin
      prescaler   <= us_tick ? '0 : prescaler + 1'b1;
      if (us_tick)
        frame_us  <= wrap ? '0 : frame_us + 1'b1;
      frame_start <= wrap;

      if (!armed) begin
        state   <= ST_DISARMED;
        running <= 1'b0;
      end else begin
        case (state)
          ST_DISARMED: begin
            running <= 1'b0;
            // Only start at a wrap so the first pulse is never partial.
            if (wrap) begin
              state   <= ST_ARMING;
              arm_cnt <= '0;
            end
          end
          ST_ARMING: begin
            if (wrap) begin
              if (arm_cnt == AC_W'(ARM_FRAMES - 1)) begin
                state   <= ST_RUN;
                running <= 1'b1;
              end else begin
                arm_cnt <= arm_cnt + 1'b1;
              end
            end
          end
          ST_RUN: begin
            running <= 1'b1;
          end
          default: begin
            state   <= ST_DISARMED;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rate_a[0] = motor_1_rate;
  assign rate_a[1] = motor_2_rate;
  assign rate_a[2] = motor_3_rate;
  assign rate_a[3] = motor_4_rate;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    esc_pwm_channel #(
      .RATE_W      (RATE_W),
      .MIN_PULSE_US(MIN_PULSE_US),
      .MAX_PULSE_US(MAX_PULSE_US),
      .FU_W        (FU_W)
    ) u_ch (
      .sys_clk (sys_clk),
      .reset   (reset),
      .load    (wrap),
      .enable  (ch_enable),
      .use_min (ch_use_min),
      .rate    (rate_a[g]),
      .frame_us(frame_us),
      .pwm     (pwm_a[g])
    );
  end

  assign motor_1_pwm = pwm_a[0];
  assign motor_2_pwm = pwm_a[1];
  assign motor_3_pwm = pwm_a[2];
  assign motor_4_pwm = pwm_a[3];

endmodule

// File: tb/tb_esc_pwm_engine.sv
// Testbench for esc_pwm_engine, run with shortened timing (4 MHz clock,
// 250 us frame, 100..200 us pulses, 4 arming frames) so every scenario fits
// in a short run while keeping the same proportions as the flight setup.
module tb_esc_pwm_engine;

  localparam int CLK_HZ   = 4_000_000;
  localparam int DIV      = 4;
  localparam int FRAME_US = 250;
  localparam int MIN_US   = 100;
  localparam int MAX_US   = 200;
  localparam int ARM      = 4;
  localparam int RATE_W   = 8;
  localparam int FRAME    = DIV * FRAME_US;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        armed   = 1'b0;
  logic [31:0] rates   = '0;
  logic [3:0]  pwm;
  logic        frame_start;
  logic        running;

  int checks   = 0;
  int failures = 0;
  int mdl_n    = 0;   // arming frames the model has seen since arm
  int meas [4];

  always #5 sys_clk = ~sys_clk;

  esc_pwm_engine #(
    .CLK_FREQ_HZ (CLK_HZ),
    .FRAME_US    (FRAME_US),
    .MIN_PULSE_US(MIN_US),
    .MAX_PULSE_US(MAX_US),
    .ARM_FRAMES  (ARM),
    .RATE_W      (RATE_W)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .armed       (armed),
    .motor_1_rate(rates[7:0]),
    .motor_2_rate(rates[15:8]),
    .motor_3_rate(rates[23:16]),
    .motor_4_rate(rates[31:24]),
    .motor_1_pwm (pwm[0]),
    .motor_2_pwm (pwm[1]),
    .motor_3_pwm (pwm[2]),
    .motor_4_pwm (pwm[3]),
    .frame_start (frame_start),
    .running     (running)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse width in us for a rate, straight from the linear map and clamp.
  function automatic int exp_us(input int rate);
    int w;
    w = MIN_US + (rate * (MAX_US - MIN_US)) / (1 << RATE_W);
    if (w < MIN_US) w = MIN_US;
    if (w > MAX_US) w = MAX_US;
    return w;
  endfunction

  task automatic wait_strobe(output int waits);
    waits = 0;
    do begin
      @(negedge sys_clk);
      waits++;
    end while (!frame_start && waits < 3 * FRAME);
    if (!frame_start) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: got no frame_start within %0d cycles", waits);
    end
  endtask

  // Observe one full frame starting at its frame_start strobe. At sample
  // chg_off the inputs may be changed (rates and/or armed).
  task automatic run_frame(input string tag, input int chg_off, input logic [31:0] new_rates,
                           input bit set_rates, input bit set_arm, input logic new_arm);
    int waits, stray, exp_run;
    int exp [4];
    int hi [4];
    bit drop;
    wait_strobe(waits);
    check($sformatf("%s_period", tag), waits, 1);
    if (!armed) begin
      mdl_n = 0;
      exp_run = 0;
      for (int m = 0; m < 4; m++) exp[m] = 0;
    end else if (mdl_n < ARM) begin
      mdl_n++;
      exp_run = 0;
      for (int m = 0; m < 4; m++) exp[m] = MIN_US * DIV;
    end else begin
      exp_run = 1;
      for (int m = 0; m < 4; m++) exp[m] = exp_us(int'(rates[8*m +: 8])) * DIV;
    end
    check($sformatf("%s_running", tag), int'(running), exp_run);
    drop = set_arm && !new_arm && armed;
    stray = 0;
    for (int m = 0; m < 4; m++) hi[m] = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge sys_clk);
      for (int m = 0; m < 4; m++) hi[m] += int'(pwm[m]);
      if (i > 0 && frame_start) stray++;
      if (drop && i == chg_off + 1) begin
        check($sformatf("%s_cut_pwm", tag), int'(pwm), 0);
        check($sformatf("%s_cut_running", tag), int'(running), 0);
      end
      if (i == chg_off) begin
        if (set_rates) rates = new_rates;
        if (set_arm) armed = new_arm;
      end
    end
    if (drop) begin
      mdl_n = 0;
      for (int m = 0; m < 4; m++) if (exp[m] > chg_off) exp[m] = chg_off;
    end
    check($sformatf("%s_stray_strobe", tag), stray, 0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_m%0d_width", tag, m + 1), hi[m], exp[m]);
      meas[m] = hi[m];
    end
  endtask

  // Called at the first negedge after the reset edge: nothing may pulse and
  // no strobe may appear until a full frame has elapsed.
  task automatic after_reset_check(input string tag);
    int hi, strobes;
    hi = 0;
    strobes = 0;
    mdl_n = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      @(negedge sys_clk);
      hi += int'(pwm[0]) + int'(pwm[1]) + int'(pwm[2]) + int'(pwm[3]);
      strobes += int'(frame_start);
    end
    check($sformatf("%s_quiet_pwm", tag), hi, 0);
    check($sformatf("%s_no_early_strobe", tag), strobes, 0);
  endtask

  typedef struct {
    logic [31:0]      rates;
    logic [3:0][15:0] us;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int w;
    tbl[0].rates = {8'd64, 8'd255, 8'd128, 8'd0};
    tbl[0].us    = {16'd125, 16'd199, 16'd150, 16'd100};
    tbl[1].rates = {8'd4, 8'd3, 8'd2, 8'd1};
    tbl[1].us    = {16'd101, 16'd101, 16'd100, 16'd100};
    tbl[2].rates = {8'd129, 8'd127, 8'd254, 8'd255};
    tbl[2].us    = {16'd150, 16'd149, 16'd199, 16'd199};
    tbl[3].rates = {8'd200, 8'd100, 8'd50, 8'd10};
    tbl[3].us    = {16'd178, 16'd139, 16'd119, 16'd103};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_running", int'(running), 0);
    reset = 1'b0;
    after_reset_check("rst");

    // Disarmed frames
    for (int k = 0; k < 3; k++) run_frame("s1_off", -1, '0, 0, 0, 0);

    // Arm mid-frame: waits for the wrap, then 4 minimum frames, then live
    run_frame("s2_pre", 500, {4{8'd200}}, 1, 1, 1'b1);
    for (int k = 0; k < ARM; k++) run_frame("s2_arming", -1, '0, 0, 0, 0);
    run_frame("s2_run", -1, '0, 0, 0, 0);
    check("s2_run_width_hand", meas[0], 178 * DIV);

    // Table of rate sets in RUN
    for (int k = 0; k < 4; k++) begin
      run_frame("s3_load", 500, tbl[k].rates, 1, 0, 0);
      run_frame("s3_vec", -1, '0, 0, 0, 0);
      for (int m = 0; m < 4; m++)
        check($sformatf("s3_tbl%0d_m%0d", k, m + 1), meas[m], int'(tbl[k].us[m]) * DIV);
    end

    // Mid-frame rate change is deferred to the next frame
    run_frame("s4_load", 500, {8'd10, 8'd20, 8'd30, 8'd0}, 1, 0, 0);
    run_frame("s4_chg", 200, {8'd10, 8'd20, 8'd30, 8'd255}, 1, 0, 0);
    check("s4_this_frame", meas[0], 100 * DIV);
    run_frame("s4_next", -1, '0, 0, 0, 0);
    check("s4_next_frame", meas[0], 199 * DIV);

    // Random rates changed at random points inside the frame
    for (int k = 0; k < 8; k++)
      run_frame("rnd", int'($urandom_range(900, 20)), $urandom, 1, 0, 0);

    // Disarm mid-pulse truncates, re-arm replays the arming sequence
    run_frame("s5_load", 500, {4{8'd255}}, 1, 0, 0);
    run_frame("s5_disarm", 480, '0, 0, 1, 1'b0);
    check("s5_truncated_hand", meas[3], 480);
    run_frame("s5_off", 100, '0, 0, 1, 1'b1);
    for (int k = 0; k < ARM; k++) run_frame("s5_rearm", -1, '0, 0, 0, 0);
    run_frame("s5_run", -1, '0, 0, 0, 0);

    // Reset mid-pulse in RUN
    wait_strobe(w);
    check("s6_period", w, 1);
    repeat (280) @(negedge sys_clk);
    check("s6_pre_pwm", int'(pwm), 15);
    reset = 1'b1;
    @(negedge sys_clk);
    check("s6_rst_pwm", int'(pwm), 0);
    check("s6_rst_running", int'(running), 0);
    reset = 1'b0;
    after_reset_check("s6");
    for (int k = 0; k < ARM; k++) run_frame("s6_rearm", -1, '0, 0, 0, 0);
    run_frame("s6_run", -1, '0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
